// File: rtl/four_bank_pkg.sv
// Shared constants and field helpers for the four-bank memory responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package four_bank_pkg;

  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 16;
  localparam int NUM_BANKS    = 4;

  // Word-interleaved banks: consecutive 16-bit words land in consecutive banks.
  localparam int BANK_SEL_LSB = 1;
  localparam int BANK_SEL_W   = 2;
  localparam int ROW_LSB      = 3;
  localparam int ROW_MSB      = 15;

  // Occupancy counter width; holds BANK_CYCLES-1 for BANK_CYCLES up to 15.
  localparam int CNT_W        = 4;

  typedef logic [BANK_SEL_W-1:0] bank_sel_t;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dat;
  } mem_req_t;

  function automatic bank_sel_t bank_of(input logic [ADDR_W-1:0] a);
    return a[BANK_SEL_LSB +: BANK_SEL_W];
  endfunction

endpackage

// File: rtl/four_bank_mem_bank.sv
// One memory bank: word array, occupancy counter, write and read-capture logic.
// Latency: write lands at the accept edge; read word captured into rdata at the accept edge.
// Backpressure: none internally; busy tells the top level to refuse new accesses.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears the counter only)
//   accept    - access to this bank accepted this cycle
//   we        - accepted access is a write (otherwise a read)
//   row       - word index within the bank
//   wdata     - write data
//   rdata     - read data captured at the accept edge (pipe stage 1)
//   busy      - occupancy counter is nonzero
module mem_bank
  import four_bank_pkg::*;
#(
  parameter int ROW_BITS    = 13,
  parameter int BANK_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                accept,
  input  logic                we,
  input  logic [ROW_BITS-1:0] row,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                busy
);

  // Accept cycle counts as the first occupied cycle, so load one less.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BANK_CYCLES - 1);

  logic [DATA_W-1:0] mem [2**ROW_BITS];
  logic [CNT_W-1:0]  cnt;

  // Loads only happen while cnt==0 (the top refuses busy banks), so load
  // and decrement never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Array and capture register are deliberately outside reset: contents
  // survive reset, and rdata is only consumed when the top marks it valid.
  always_ff @(posedge clk) begin
    if (accept && we) begin
      mem[row] <= wdata;
    end
    if (accept && !we) begin
      rdata <= mem[row];
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/four_bank_mem.sv
// Banked memory responder: four word-interleaved banks behind a single request port.
// Latency: read data on data_out exactly 2 cycles after the accept cycle; writes land at the accept edge.
// Backpressure: stall (combinational) while the addressed bank is busy; initiator must hold the request.
//
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   createdump  - dump nonzero words (only with FOUR_BANK_MEM_DUMP_EN defined)
//   addr        - byte address, bit 0 must be 0; bank = addr[2:1], row = addr[15:3]
//   data_in     - write data
//   wr, rd      - write / read request
//   data_out    - read data, 0 in cycles with no read completing
//   stall       - request refused because its bank is busy
//   busy        - per-bank occupied flags
//   err         - illegal request (rd&wr, or misaligned address)
//
// Optional build macro FOUR_BANK_MEM_DUMP_EN enables the simulation-only dump.
module four_bank_mem
  import four_bank_pkg::*;
#(
  parameter int BANK_CYCLES = 4,
  parameter int ROW_BITS    = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 createdump,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 wr,
  input  logic                 rd,
  output logic [DATA_W-1:0]    data_out,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);

  mem_req_t            req;
  logic                req_vld;
  logic                illegal;
  logic                accept;
  bank_sel_t           sel;
  logic [ROW_BITS-1:0] row;

  logic [DATA_W-1:0]   bank_rdata [NUM_BANKS];

  // Read pipe: stage 1 lives in the banks (rdata), tracked here by s1_vld/s1_bank.
  logic                s1_vld;
  bank_sel_t           s1_bank;
  logic [DATA_W-1:0]   s2_dat;

  assign req     = '{rd: rd, wr: wr, addr: addr, dat: data_in};
  assign req_vld = req.rd | req.wr;
  assign sel     = bank_of(req.addr);
  assign row     = req.addr[ROW_LSB +: ROW_BITS];

  assign illegal = (req.rd & req.wr) | (req_vld & req.addr[0]);

  // Illegal requests never stall; everything is masked while in reset.
  assign err     = !rst & illegal;
  assign stall   = !rst & req_vld & !illegal &  busy[sel];
  assign accept  = !rst & req_vld & !illegal & !busy[sel];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mem_bank #(
      .ROW_BITS    (ROW_BITS),
      .BANK_CYCLES (BANK_CYCLES)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .accept (accept && (sel == bank_sel_t'(b))),
      .we     (req.wr),
      .row    (row),
      .wdata  (req.dat),
      .rdata  (bank_rdata[b]),
      .busy   (busy[b])
    );
  end

  // Stage 2 holds zero unless a read is completing, so data_out needs no gating.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_bank <= '0;
      s2_dat  <= '0;
    end else begin
      s1_vld  <= accept & req.rd;
      s1_bank <= sel;
      s2_dat  <= s1_vld ? bank_rdata[s1_bank] : '0;
    end
  end

  assign data_out = s2_dat;

`ifdef FOUR_BANK_MEM_DUMP_EN
  // Walk rows outermost and banks innermost so byte addresses come out ascending.
  task automatic dump_mem();
    logic [DATA_W-1:0] w;
    for (int r = 0; r < 2**ROW_BITS; r++) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        case (b)
          0:       w = g_bank[0].u_bank.mem[r];
          1:       w = g_bank[1].u_bank.mem[r];
          2:       w = g_bank[2].u_bank.mem[r];
          default: w = g_bank[3].u_bank.mem[r];
        endcase
        if (w != '0) begin
          $display("%04h %04h", ADDR_W'((r * NUM_BANKS + b) * 2), w);
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (createdump && !rst) begin
      dump_mem();
    end
  end
`else
  logic unused_createdump;
  assign unused_createdump = createdump;
`endif

endmodule

// File: tb/tb_four_bank_mem.sv
// Self-checking bench for four_bank_mem: directed scenarios followed by random traffic,
// all compared against a timestamp-based model (bank free times, due-cycle read results).
module tb_four_bank_mem;

  localparam int BC = 4;

  logic        clk;
  logic        rst;
  logic        createdump;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  four_bank_mem #(.BANK_CYCLES(BC), .ROW_BITS(13)) dut (
    .clk        (clk),
    .rst        (rst),
    .createdump (createdump),
    .addr       (addr),
    .data_in    (data_in),
    .wr         (wr),
    .rd         (rd),
    .data_out   (data_out),
    .stall      (stall),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: memory by word index, per-bank cycle at which the bank is free
  // again, and the value data_out must show in a given future cycle.
  logic [15:0] mdl [int];
  logic [15:0] due [int];
  bit          dc  [int];
  int          free_at [4];
  int          cyc = 0;

  logic [3:0]  obs_busy;
  logic        obs_stall;
  logic        obs_err;
  logic [15:0] obs_dout;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, compare outputs mid-cycle, then advance the model at the edge.
  task automatic cycle(input bit r, input bit w, input logic [15:0] a,
                       input logic [15:0] d, input bit rs);
    logic [3:0]  eb;
    logic [15:0] ed;
    bit          reqv, ill, acc;
    int          b;
    int          kill[$];
    rd = r; wr = w; addr = a; data_in = d; rst = rs; createdump = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) eb[i] = (cyc < free_at[i]);
    b    = int'(a[2:1]);
    reqv = r | w;
    ill  = !rs && ((r && w) || (reqv && a[0]));
    acc  = !rs && reqv && !ill && !eb[b];
    ed   = due.exists(cyc) ? due[cyc] : 16'h0000;
    obs_busy = busy; obs_stall = stall; obs_err = err; obs_dout = data_out;
    chk("busy",  16'(busy),  16'(eb));
    chk("stall", 16'(stall), 16'(!rs && reqv && !ill && eb[b]));
    chk("err",   16'(err),   16'(ill));
    if (!dc.exists(cyc)) chk("data_out", data_out, ed);
    @(posedge clk);
    if (rs) begin
      for (int i = 0; i < 4; i++) free_at[i] = 0;
      foreach (due[k]) if (k > cyc) kill.push_back(k);
      foreach (kill[j]) due.delete(kill[j]);
      kill.delete();
      foreach (dc[k]) if (k > cyc) kill.push_back(k);
      foreach (kill[j]) dc.delete(kill[j]);
    end else if (acc) begin
      free_at[b] = cyc + BC;
      if (r) begin
        if (mdl.exists(int'(a[15:1]))) due[cyc + 2] = mdl[int'(a[15:1])];
        else dc[cyc + 2] = 1'b1;
      end else begin
        mdl[int'(a[15:1])] = d;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
  endtask

  initial begin
    int          nstall;
    int          op;
    int          idx;
    logic [15:0] a;
    logic [3:0]  walk [4];
    walk = '{4'b0001, 4'b0011, 4'b0111, 4'b1110};

    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0; createdump = 1'b0;
    for (int i = 0; i < 4; i++) free_at[i] = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    chk("reset_busy", 16'(obs_busy), 16'h0000);
    chk("reset_dout", obs_dout, 16'h0000);

    // Fill a 32-word window; consecutive banks, so no stalls.
    for (int i = 0; i < 32; i++) begin
      cycle(1'b0, 1'b1, 16'(2 * i), 16'hA000 + 16'(i), 1'b0);
      chk("init_stall", 16'(obs_stall), 16'h0000);
    end
    idle(4);

    // Write then read back 0xBEEF at 0x0100.
    cycle(1'b0, 1'b1, 16'h0100, 16'hBEEF, 1'b0);
    idle(4);
    cycle(1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0);
    chk("beef_err",   16'(obs_err),   16'h0000);
    chk("beef_stall", 16'(obs_stall), 16'h0000);
    idle(1); chk("beef_t1", obs_dout, 16'h0000);
    idle(1); chk("beef_t2", obs_dout, 16'hBEEF);
    idle(1); chk("beef_t3", obs_dout, 16'h0000);
    idle(4);

    // Line writeback then line fill at 0x1230..0x1236.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 16'h1230 + 16'(2 * i), 16'h1111 * 16'(i + 1), 1'b0);
    idle(4);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 16'h1230 + 16'(2 * i), 16'h0000, 1'b0);
      chk("fill_stall", 16'(obs_stall), 16'h0000);
      if (i > 0) chk("fill_busy", 16'(obs_busy), 16'(walk[i-1]));
      if (i == 2) chk("fill_d0", obs_dout, 16'h1111);
      if (i == 3) chk("fill_d1", obs_dout, 16'h2222);
    end
    idle(1);
    chk("fill_busy", 16'(obs_busy), 16'(walk[3]));
    chk("fill_d2", obs_dout, 16'h3333);
    idle(1);
    chk("fill_d3", obs_dout, 16'h4444);
    idle(4);

    // Bank conflict on bank 0: held read stalls for BC-1 cycles.
    cycle(1'b0, 1'b1, 16'h0000, 16'h5555, 1'b0);
    nstall = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 16'h0008, 16'h0000, 1'b0);
      if (!obs_stall) break;
      nstall++;
    end
    chk("conflict_stalls", 16'(nstall), 16'(BC - 1));
    idle(1); chk("conflict_t5", obs_dout, 16'h0000);
    idle(1); chk("conflict_t6", obs_dout, 16'hA004);
    idle(4);

    // Illegal requests: err only, nothing accepted or returned.
    cycle(1'b1, 1'b1, 16'h0004, 16'h7777, 1'b0);
    chk("ill_rdwr_err", 16'(obs_err), 16'h0001);
    cycle(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0);
    chk("ill_odd_err",   16'(obs_err),   16'h0001);
    chk("ill_odd_stall", 16'(obs_stall), 16'h0000);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("ill_busy", 16'(obs_busy), 16'h0000);
      chk("ill_dout", obs_dout, 16'h0000);
    end

    // Reset while a read is in flight.
    cycle(1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0);
    cycle(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b1);
    chk("rst_err",   16'(obs_err),   16'h0000);
    chk("rst_stall", 16'(obs_stall), 16'h0000);
    idle(1);
    chk("rst_dout", obs_dout, 16'h0000);
    chk("rst_busy", 16'(obs_busy), 16'h0000);
    idle(1);
    cycle(1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0);
    idle(2);
    chk("rst_keep", obs_dout, 16'hBEEF);
    idle(4);

    // Random traffic over the initialised window.
    for (int n = 0; n < 1500; n++) begin
      op  = int'($urandom_range(0, 99));
      idx = int'($urandom_range(0, 31));
      a   = 16'(idx * 2);
      if      (op < 35) cycle(1'b1, 1'b0, a, 16'($urandom), 1'b0);
      else if (op < 70) cycle(1'b0, 1'b1, a, 16'($urandom), 1'b0);
      else if (op < 74) cycle(1'b1, 1'b1, a, 16'($urandom), 1'b0);
      else if (op < 78) cycle(1'b1, 1'b0, a | 16'h0001, 16'h0000, 1'b0);
      else if (op < 80) cycle(1'b1, 1'b0, a, 16'h0000, 1'b1);
      else              cycle(1'b0, 1'b0, a, 16'h0000, 1'b0);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
